// File: rtl/ysyx_25040111_ifu.sv
// rtl/ysyx_25040111_ifu.sv - instruction fetch unit: AXI4-Lite read fetch, decode handoff, jump redirect
module ysyx_25040111_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ifu_inst,
    output logic [31:0] ifu_pc,
    output logic        ifu_fault,
    output logic        ifu_valid,
    input  logic        ifu_ready,
    input  logic        jump,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AR       = 3'd1,
        R        = 3'd2,
        OUT      = 3'd3,
        CHECK    = 3'd4,
        WAIT_JMP = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        ifu_valid_q, ifu_valid_d;
    logic [31:0] redir_target;

    assign redir_target = redir_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: state_d = AR;
            AR: if (arready) state_d = R;
            R: begin
                if (rvalid) begin
                    inst_d  = rdata;
                    fault_d = (rresp != 2'b00);
                    state_d = OUT;
                end
            end
            OUT: if (ifu_ready) state_d = CHECK;
            // decode latched the instruction at the handoff edge, so jump is valid only now
            CHECK: begin
                if (!jump) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = AR;
                end else if (redir_valid) begin
                    pc_d    = redir_target;
                    state_d = AR;
                end else begin
                    state_d = WAIT_JMP;
                end
            end
            WAIT_JMP: begin
                if (redir_valid) begin
                    pc_d    = redir_target;
                    state_d = AR;
                end
            end
            default: state_d = IDLE;
        endcase
        arvalid_d   = (state_d == AR);
        rready_d    = (state_d == R);
        ifu_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'h0;
            fault_q     <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ifu_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            fault_q     <= fault_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ifu_valid_q <= ifu_valid_d;
        end
    end

    assign araddr    = pc_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign ifu_valid = ifu_valid_q;
    assign ifu_inst  = inst_q;
    assign ifu_pc    = pc_q;
    assign ifu_fault = fault_q;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// tb/tb_ysyx_25040111_ifu.sv - randomized scoreboard bench for the fetch unit
module tb_ysyx_25040111_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifu_inst, ifu_pc, araddr, redir_pc, rdata;
    logic        ifu_fault, ifu_valid, ifu_ready, jump, redir_valid;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp;

    ysyx_25040111_ifu #(.RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .ifu_inst(ifu_inst), .ifu_pc(ifu_pc), .ifu_fault(ifu_fault),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
        .jump(jump), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } fetch_t;

    fetch_t      exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_ar = -1;
    int          n_handoff = 0;
    int          fast_until = 4;
    int          wait_cnt = 0;
    bit          waiting = 0;
    bit          check_next = 0;
    bit          expect_ar = 0;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] wait_tgt = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of memory slave + decode behaviour, called just after a falling edge.
    task automatic drive_cycle();
        bit          jmp;
        logic [31:0] tgt;
        int          dly;
        fetch_t      f;
        cyc++;
        arready = 0; rvalid = 0; ifu_ready = 0; jump = 0; redir_valid = 0;
        redir_pc = $urandom;
        if (expect_ar) begin
            chk("ar_after_pc_update", {31'h0, arvalid}, 32'h1);
            expect_ar = 0;
        end
        if (arvalid && (n_handoff < fast_until || $urandom_range(3, 0) != 0)) begin
            arready = 1;
            chk("araddr", araddr, model_pc);
            if (n_handoff < fast_until && last_ar >= 0)
                chk("fetch_period", 32'(cyc - last_ar), 32'd4);
            last_ar = cyc;
        end
        if (rready && (n_handoff < fast_until || $urandom_range(2, 0) == 0)) begin
            rvalid = 1;
            if (n_handoff < fast_until) begin
                rdata = 32'h0000_0013; rresp = 2'b00;
            end else begin
                rdata = $urandom;
                rresp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            end
            f.inst = rdata; f.pc = model_pc; f.fault = (rresp != 2'b00);
            exp_q.push_back(f);
        end
        if (check_next) begin
            check_next = 0;
            tgt = $urandom; dly = 0; jmp = 0;
            if (n_handoff < fast_until) jmp = 0;
            else if (n_handoff == 4) begin jmp = 1; tgt = 32'h8000_0103; dly = 0; end
            else if (n_handoff == 5) begin jmp = 1; tgt = 32'hFFFF_FFFF; dly = 6; end
            else if (n_handoff == 6) jmp = 0;
            else begin
                jmp = ($urandom_range(9, 0) < 3);
                dly = $urandom_range(6, 0);
            end
            n_handoff++;
            if (!jmp) begin
                model_pc = model_pc + 32'd4;
                expect_ar = 1;
            end else begin
                jump = 1;
                if (dly == 0) begin
                    redir_valid = 1; redir_pc = tgt;
                    model_pc = {tgt[31:2], 2'b00};
                    expect_ar = 1;
                end else begin
                    waiting = 1; wait_cnt = dly; wait_tgt = tgt;
                end
            end
        end else if (waiting) begin
            chk("no_arvalid_in_wait", {31'h0, arvalid}, 32'h0);
            wait_cnt--;
            if (wait_cnt == 0) begin
                redir_valid = 1; redir_pc = wait_tgt;
                model_pc = {wait_tgt[31:2], 2'b00};
                waiting = 0; expect_ar = 1;
            end
        end else if ($urandom_range(7, 0) == 0) begin
            redir_valid = 1;
        end
        if (ifu_valid) begin
            ifu_ready = (n_handoff < fast_until) || ($urandom_range(2, 0) == 0);
            if (ifu_ready) check_next = 1;
        end
    endtask

    initial begin : monitor
        fetch_t e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset && ifu_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'h1, 32'h0);
                end else begin
                    e = exp_q[0];
                    chk("ifu_inst", ifu_inst, e.inst);
                    chk("ifu_pc", ifu_pc, e.pc);
                    chk("ifu_fault", {31'h0, ifu_fault}, {31'h0, e.fault});
                    if (ifu_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1; ifu_ready = 0; jump = 0; redir_valid = 0; redir_pc = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        repeat (3) @(negedge clock);
        chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
        chk("rst_rready", {31'h0, rready}, 32'h0);
        chk("rst_ifu_valid", {31'h0, ifu_valid}, 32'h0);
        chk("rst_araddr", araddr, RST_PC);
        chk("rst_ifu_pc", ifu_pc, RST_PC);
        chk("rst_ifu_inst", ifu_inst, 32'h0);
        chk("rst_ifu_fault", {31'h0, ifu_fault}, 32'h0);
        reset = 0;
        expect_ar = 1;
        while (n_handoff < 150 && cyc < 20000) begin
            @(negedge clock);
            drive_cycle();
        end
        chk("handoffs_before_budget", {31'h0, n_handoff >= 150}, 32'h1);

        begin : reset_in_r
            int guard = 0;
            forever begin
                @(negedge clock);
                if (rready || guard > 200) break;
                drive_cycle();
                guard++;
            end
            chk("reached_r_state", {31'h0, rready}, 32'h1);
        end
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        arready = 0; ifu_ready = 0; jump = 0; redir_valid = 0;
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        reset = 1;
        @(negedge clock);
        chk("midrst_rready", {31'h0, rready}, 32'h0);
        chk("midrst_ifu_valid", {31'h0, ifu_valid}, 32'h0);
        chk("midrst_arvalid", {31'h0, arvalid}, 32'h0);
        chk("midrst_ifu_pc", ifu_pc, RST_PC);
        chk("midrst_ifu_inst", ifu_inst, 32'h0);
        reset = 0; rvalid = 0;
        exp_q.delete();
        model_pc = RST_PC; check_next = 0; waiting = 0; last_ar = -1;
        expect_ar = 1;
        fast_until = n_handoff + 3;
        begin : after_reset
            int guard = 0;
            while (n_handoff < fast_until && guard < 200) begin
                @(negedge clock);
                drive_cycle();
                guard++;
            end
        end
        chk("restart_handoffs", {31'h0, n_handoff >= fast_until}, 32'h1);
        repeat (3) @(negedge clock);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
